// File: rtl/vec_mul_pkg.sv
// ============================================================================
// Module  : vec_mul_pkg
// Brief   : Shared width constants and the FILL/HOLD stage state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BITS
`define BITS 8
`endif
`ifndef VEC_LEN
`define VEC_LEN 4
`endif

package vec_mul_pkg;

  localparam int c_STATE_W = 1;

  // Collect stages: FILL gathers elements, HOLD presents the finished vector.
  typedef enum logic [c_STATE_W-1:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } stage_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_mul.sv
// ============================================================================
// Module  : sat_mul
// Brief   : Combinational signed multiply, saturated to OUT_BITS.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_mul #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 8
) (
  input  logic signed [IN_BITS-1:0]  a,
  input  logic signed [IN_BITS-1:0]  b,
  output logic signed [OUT_BITS-1:0] product,
  output logic                       sat
);

  localparam int c_PW = 2 * IN_BITS;

  // Clamp bounds expressed at full product width so the compare stays signed.
  localparam logic signed [c_PW-1:0] c_MAX =
    {{(c_PW - OUT_BITS + 1){1'b0}}, {(OUT_BITS - 1){1'b1}}};
  localparam logic signed [c_PW-1:0] c_MIN =
    {{(c_PW - OUT_BITS + 1){1'b1}}, {(OUT_BITS - 1){1'b0}}};

  logic signed [c_PW-1:0] w_full;

  assign w_full = a * b;

  always_comb begin
    product = w_full[OUT_BITS-1:0];
    sat     = 1'b0;
    if (w_full > c_MAX) begin
      product = c_MAX[OUT_BITS-1:0];
      sat     = 1'b1;
    end else if (w_full < c_MIN) begin
      product = c_MIN[OUT_BITS-1:0];
      sat     = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_mul_stage.sv
// ============================================================================
// Module  : vec_mul_stage
// Brief   : Collects VEC_LEN saturated products and holds them for the summer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mul_stage
  import vec_mul_pkg::*;
#(
  parameter int IN_BITS  = `BITS,
  parameter int OUT_BITS = `BITS,
  parameter int VEC_LEN  = `VEC_LEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_BITS-1:0]  in_act,
  input  logic signed [IN_BITS-1:0]  in_wgt,
  input  logic                       in_relu,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_BITS-1:0] out_vec [VEC_LEN],
  output logic                       out_relu,
  output logic                       out_ovf
);

  localparam int c_IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(VEC_LEN - 1);

  stage_state_e               r_state;
  stage_state_e               w_next_state;
  logic [c_IDX_W-1:0]         r_idx;
  logic signed [OUT_BITS-1:0] r_vec [VEC_LEN];
  logic                       r_relu;
  logic                       r_ovf;
  logic                       w_accept;
  logic signed [OUT_BITS-1:0] w_prod;
  logic                       w_sat;

  sat_mul #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_sat_mul (
    .a       (in_act),
    .b       (in_wgt),
    .product (w_prod),
    .sat     (w_sat)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_FILL;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FILL: if (w_accept && (r_idx == c_LAST)) w_next_state = ST_HOLD;
      ST_HOLD: if (out_ready)                     w_next_state = ST_FILL;
      default: w_next_state = ST_FILL;
    endcase
  end

  // Handshakes are masked during reset so nothing leaks out of a discarded vector.
  always_comb begin
    in_ready  = (r_state == ST_FILL) && !reset;
    out_valid = (r_state == ST_HOLD) && !reset;
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx  <= '0;
      r_relu <= 1'b0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) r_vec[i] <= '0;
    end else if (w_accept) begin
      r_vec[r_idx] <= w_prod;
      r_idx        <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
      if (r_idx == '0) begin
        r_relu <= in_relu;
        r_ovf  <= w_sat;
      end else begin
        r_ovf  <= r_ovf | w_sat;
      end
    end
  end

  assign out_vec  = r_vec;
  assign out_relu = r_relu;
  assign out_ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_vec_mul_stage.sv
// ============================================================================
// Module  : tb_vec_mul_stage
// Brief   : Scoreboard bench for vec_mul_stage with a behavioural product model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_mul_stage;

  localparam int NB = 8;
  localparam int NL = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [NB-1:0] in_act = '0;
  logic signed [NB-1:0] in_wgt = '0;
  logic                 in_relu = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [NB-1:0] out_vec [NL];
  logic                 out_relu;
  logic                 out_ovf;

  vec_mul_stage #(.IN_BITS(NB), .OUT_BITS(NB), .VEC_LEN(NL)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .in_relu   (in_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_relu  (out_relu),
    .out_ovf   (out_ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NB*NL-1:0] v;
    logic             relu;
    logic             ovf;
    logic signed [31:0] dot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   va[NL], vb[NL], gaps[NL];
  int   hold_target = 0;
  int   hold_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Downstream backpressure: hold off out_ready for hold_target cycles of each vector.
  always @(negedge clock) begin
    if (!out_valid) begin
      hold_cnt  = 0;
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = (hold_cnt >= hold_target);
      hold_cnt++;
    end
  end

  // Monitor: pop on each new vector, then verify it stays frozen until handed off.
  exp_t cur;
  bit   seen = 0;
  bit   prev_valid = 0;
  always @(negedge clock) begin
    if (reset) begin
      seen       = 0;
      prev_valid = 0;
    end else begin
      if (out_valid && !seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vector", 1, 0);
        end else begin
          int sum;
          cur = exp_q.pop_front();
          sum = 0;
          for (int i = 0; i < NL; i++) begin
            chk($sformatf("vec[%0d]", i), int'(out_vec[i]), int'($signed(cur.v[i*NB +: NB])));
            sum += int'(out_vec[i]);
          end
          chk("out_relu", int'(out_relu), int'(cur.relu));
          chk("out_ovf", int'(out_ovf), int'(cur.ovf));
          if (out_relu && sum < 0) sum = 0;
          chk("dot_product", sum, int'(cur.dot));
        end
        seen = 1;
      end else if (out_valid && seen) begin
        for (int i = 0; i < NL; i++)
          chk($sformatf("hold_vec[%0d]", i), int'(out_vec[i]), int'($signed(cur.v[i*NB +: NB])));
        chk("hold_ovf", int'(out_ovf), int'(cur.ovf));
        chk("hold_in_ready", int'(in_ready), 0);
      end
      if (!out_valid && prev_valid) begin
        chk("release_in_ready", int'(in_ready), 1);
        seen = 0;
      end
      prev_valid = out_valid;
    end
  end

  task automatic send_pair(input int a, input int b, input bit r);
    bit acc;
    int n;
    @(negedge clock);
    in_valid = 1'b1;
    in_act   = 8'(a);
    in_wgt   = 8'(b);
    in_relu  = r;
    n = 0;
    forever begin
      acc = in_ready;
      @(posedge clock);
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic send_vec(input bit relu);
    exp_t e;
    int   p, dot;
    e = '0;
    dot = 0;
    for (int i = 0; i < NL; i++) begin
      p = va[i] * vb[i];
      if (p > 127)  begin p = 127;  e.ovf = 1'b1; end
      if (p < -128) begin p = -128; e.ovf = 1'b1; end
      e.v[i*NB +: NB] = 8'(p);
      dot += p;
    end
    e.relu = relu;
    e.dot  = (relu && dot < 0) ? 0 : dot;
    for (int i = 0; i < NL; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clock);
        in_valid = 1'b0;
        in_act   = 8'($urandom);
        in_relu  = 1'($urandom_range(0, 1));
      end
      // Non-zero elements carry the opposite relu value; it must be ignored.
      send_pair(va[i], vb[i], (i == 0) ? relu : !relu);
    end
    exp_q.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
    chk("latency_out_valid", int'(out_valid), 1);
  endtask

  task automatic set_vec(input int a0, b0, a1, b1, a2, b2, a3, b3);
    va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1;
    va[2] = a2; vb[2] = b2; va[3] = a3; vb[3] = b3;
    for (int i = 0; i < NL; i++) gaps[i] = 0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_relu", int'(out_relu), 0);
    chk("post_reset_ovf", int'(out_ovf), 0);
    for (int i = 0; i < NL; i++) chk("post_reset_vec", int'(out_vec[i]), 0);

    // Basic fill with relu, then backpressure with ignored input pulses.
    hold_target = 10;
    set_vec(1, 2, 3, 4, -5, 6, 7, -1);
    send_vec(1'b1);
    repeat (6) begin
      @(negedge clock);
      in_valid = 1'($urandom_range(0, 1));
      in_act   = 8'($urandom);
      in_wgt   = 8'($urandom);
      in_relu  = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    hold_target = 0;
    send_vec(1'b0);

    // Saturation followed by a clean vector.
    set_vec(100, 100, -100, 100, -128, -128, 1, 1);
    send_vec(1'b0);
    set_vec(2, 3, -4, 5, 6, 7, -8, -9);
    send_vec(1'b1);

    // Gapped input: valid pattern 1,0,0,1,0,1,1.
    set_vec(9, -3, 11, 11, -12, 10, 5, 5);
    gaps[1] = 2; gaps[2] = 1;
    send_vec(1'b1);

    // Reset part-way through a fill discards the partial vector.
    send_pair(50, 2, 1'b1);
    send_pair(-7, 3, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_in_ready", int'(in_ready), 0);
    end
    reset = 1'b0;
    set_vec(1, 1, 1, 1, 1, 1, 1, 1);
    send_vec(1'b0);

    // Randomised vectors with random gaps and downstream stalls.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NL; i++) begin
        va[i]   = int'($urandom_range(0, 255)) - 128;
        vb[i]   = int'($urandom_range(0, 255)) - 128;
        gaps[i] = int'($urandom_range(0, 2));
      end
      hold_target = int'($urandom_range(0, 3));
      send_vec(1'($urandom_range(0, 1)));
    end

    begin
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
        @(negedge clock);
        n++;
      end
      chk("drain_pending", exp_q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
